// File: rtl/mem_arbiter.sv
// Shares one single-outstanding memory port between instruction fetch and the LSU. A request issues one cycle after it arrives or after the prior mem_ready.
// Each port holds at most one waiting request, and a newer one overwrites it. Define ARB_ROUND_ROBIN_EN to break ties by alternating instead of DATA_PRIO.
module mem_arbiter #(
    parameter logic DATA_PRIO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic        i_fence,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    input  logic        d_valid,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        mem_valid,
    output logic        mem_fence,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t      state_q;

    logic        ip_vld_q;
    logic        ip_fence_q;
    logic [31:0] ip_addr_q;

    logic        dp_vld_q;
    logic [31:0] dp_addr_q;
    logic [31:0] dp_wdata_q;
    logic [3:0]  dp_wstrb_q;

    logic        mem_valid_q;
    logic        mem_fence_q;
    logic        mem_instr_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_wstrb_q;

    logic        i_req;
    logic        d_req;
    logic        slot_free;
    logic        prefer_d;
    logic        issue_i;
    logic        issue_d;
    logic        resp_ok;

    logic        sel_i_fence;
    logic [31:0] sel_i_addr;
    logic [31:0] sel_d_addr;
    logic [31:0] sel_d_wdata;
    logic [3:0]  sel_d_wstrb;

`ifdef ARB_ROUND_ROBIN_EN
    logic        last_grant_q;   // 1 = data was granted last
    assign prefer_d = ~last_grant_q;
`else
    assign prefer_d = DATA_PRIO;
`endif

    // A response is never taken in the cycle the request is launched.
    assign resp_ok   = mem_ready && !mem_valid_q;
    assign slot_free = (state_q == IDLE) || resp_ok;

    assign i_req   = i_valid || ip_vld_q;
    assign d_req   = d_valid || dp_vld_q;
    assign issue_d = slot_free && d_req && (!i_req || prefer_d);
    assign issue_i = slot_free && i_req && !issue_d;

    // A same-cycle strobe is newer than anything waiting in the slot.
    assign sel_i_fence = i_valid ? i_fence : ip_fence_q;
    assign sel_i_addr  = i_valid ? i_addr  : ip_addr_q;
    assign sel_d_addr  = d_valid ? d_addr  : dp_addr_q;
    assign sel_d_wdata = d_valid ? d_wdata : dp_wdata_q;
    assign sel_d_wstrb = d_valid ? d_wstrb : dp_wstrb_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            ip_vld_q    <= 1'b0;
            ip_fence_q  <= 1'b0;
            ip_addr_q   <= 32'h0;
            dp_vld_q    <= 1'b0;
            dp_addr_q   <= 32'h0;
            dp_wdata_q  <= 32'h0;
            dp_wstrb_q  <= 4'h0;
            mem_valid_q <= 1'b0;
            mem_fence_q <= 1'b0;
            mem_instr_q <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_wstrb_q <= 4'h0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b0;
`endif
        end else begin
            mem_valid_q <= 1'b0;

            if (issue_d) begin
                state_q     <= BUSY_D;
                mem_valid_q <= 1'b1;
                mem_instr_q <= 1'b0;
                mem_fence_q <= 1'b0;
                mem_addr_q  <= sel_d_addr;
                mem_wdata_q <= sel_d_wdata;
                mem_wstrb_q <= sel_d_wstrb;
            end else if (issue_i) begin
                state_q     <= BUSY_I;
                mem_valid_q <= 1'b1;
                mem_instr_q <= 1'b1;
                mem_fence_q <= sel_i_fence;
                mem_addr_q  <= sel_i_addr;
                mem_wdata_q <= 32'h0;
                mem_wstrb_q <= 4'h0;
            end else if (slot_free) begin
                state_q     <= IDLE;
            end

`ifdef ARB_ROUND_ROBIN_EN
            if (issue_d || issue_i) begin
                last_grant_q <= issue_d;
            end
`endif

            if (issue_i) begin
                ip_vld_q   <= 1'b0;
            end else if (i_valid) begin
                ip_vld_q   <= 1'b1;
                ip_fence_q <= i_fence;
                ip_addr_q  <= i_addr;
            end

            if (issue_d) begin
                dp_vld_q   <= 1'b0;
            end else if (d_valid) begin
                dp_vld_q   <= 1'b1;
                dp_addr_q  <= d_addr;
                dp_wdata_q <= d_wdata;
                dp_wstrb_q <= d_wstrb;
            end
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_fence = mem_fence_q;
    assign mem_instr = mem_instr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

    assign i_ready = (state_q == BUSY_I) && resp_ok;
    assign i_rdata = (state_q == BUSY_I) ? mem_rdata : 32'h0;
    assign d_ready = (state_q == BUSY_D) && resp_ok;
    assign d_rdata = (state_q == BUSY_D) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter with a transaction-level reference model.
module tb_mem_arbiter;

    localparam bit DATA_PRIO = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_fence;
    logic [31:0] i_addr;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        d_valid;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        mem_valid, mem_fence, mem_instr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_PRIO(DATA_PRIO)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_fence(i_fence), .i_addr(i_addr),
        .i_ready(i_ready), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_valid(mem_valid), .mem_fence(mem_fence), .mem_instr(mem_instr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Reference model: who owns the port, what the port shows, what each requester has waiting.
    int          m_owner;     // 0 none, 1 instruction, 2 data
    bit          m_valid;
    logic        m_instr, m_fence;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    bit          pi_v, pd_v, last_d;
    logic        pi_f;
    logic [31:0] pi_a, pd_a, pd_w;
    logic [3:0]  pd_s;
    bit          grants[$];
    logic [31:0] addr_log[$];

    logic        cap_i_ready, cap_d_ready;
    logic [31:0] cap_i_rdata, cap_d_rdata;

    task automatic model_reset();
        m_owner = 0; m_valid = 0;
        m_instr = 0; m_fence = 0; m_addr = 0; m_wdata = 0; m_wstrb = 0;
        pi_v = 0; pd_v = 0; last_d = 0;
    endtask

    task automatic model_edge();
        bit can, win_d;
        if (!rst) begin
            model_reset();
            return;
        end
        can = (m_owner == 0) || (mem_ready && !m_valid);
        m_valid = 0;
        if (i_valid) begin pi_v = 1; pi_f = i_fence; pi_a = i_addr; end
        if (d_valid) begin pd_v = 1; pd_a = d_addr; pd_w = d_wdata; pd_s = d_wstrb; end
        if (can) begin
            if (pi_v && pd_v) begin
`ifdef ARB_ROUND_ROBIN_EN
                win_d = !last_d;
`else
                win_d = DATA_PRIO;
`endif
            end else begin
                win_d = pd_v;
            end
            if (pi_v || pd_v) begin
                m_valid = 1;
                if (win_d) begin
                    m_owner = 2; m_instr = 0; m_fence = 0;
                    m_addr = pd_a; m_wdata = pd_w; m_wstrb = pd_s; pd_v = 0;
                end else begin
                    m_owner = 1; m_instr = 1; m_fence = pi_f;
                    m_addr = pi_a; m_wdata = 0; m_wstrb = 0; pi_v = 0;
                end
                last_d = win_d;
                grants.push_back(win_d);
                addr_log.push_back(m_addr);
            end else begin
                m_owner = 0;
            end
        end
    endtask

    task automatic compare();
        logic        e_ir, e_dr;
        e_ir = (m_owner == 1) && mem_ready && !m_valid;
        e_dr = (m_owner == 2) && mem_ready && !m_valid;
        chk1 ("mem_valid", mem_valid, m_valid);
        chk1 ("mem_instr", mem_instr, m_instr);
        chk1 ("mem_fence", mem_fence, m_fence);
        chk32("mem_addr",  mem_addr,  m_addr);
        chk32("mem_wdata", mem_wdata, m_wdata);
        chk32("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, m_wstrb});
        chk1 ("i_ready",   i_ready,   e_ir);
        chk1 ("d_ready",   d_ready,   e_dr);
        chk32("i_rdata",   i_rdata,   (m_owner == 1) ? mem_rdata : 32'h0);
        chk32("d_rdata",   d_rdata,   (m_owner == 2) ? mem_rdata : 32'h0);
        cap_i_ready = i_ready; cap_d_ready = d_ready;
        cap_i_rdata = i_rdata; cap_d_rdata = d_rdata;
    endtask

    task automatic cycle(input bit iv, input bit ifn, input logic [31:0] ia,
                         input bit dv, input logic [31:0] da, input logic [31:0] dw,
                         input logic [3:0] ds, input bit mr, input logic [31:0] md);
        i_valid = iv; i_fence = ifn; i_addr = ia;
        d_valid = dv; d_addr = da; d_wdata = dw; d_wstrb = ds;
        mem_ready = mr; mem_rdata = md;
        @(negedge clk);
        compare();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input bit mr, input logic [31:0] md);
        cycle(0, 0, 32'h0, 0, 32'h0, 32'h0, 4'h0, mr, md);
    endtask

    initial begin
        int n, hits;
        rst = 0;
        model_reset();
        idle(0, 0);
        idle(0, 0);
        rst = 1;
        chk1 ("reset mem_valid", mem_valid, 1'b0);
        chk32("reset mem_addr", mem_addr, 32'h0);

        // Single instruction fetch.
        cycle(1, 0, 32'h100, 0, 0, 0, 0, 0, 0);
        chk1 ("t1 mem_valid", mem_valid, 1'b1);
        chk1 ("t1 mem_instr", mem_instr, 1'b1);
        chk32("t1 mem_addr", mem_addr, 32'h100);
        idle(0, 0);
        idle(1, 32'h13);
        chk1 ("t1 i_ready", cap_i_ready, 1'b1);
        chk32("t1 i_rdata", cap_i_rdata, 32'h13);
        chk1 ("t1 d_ready", cap_d_ready, 1'b0);
        idle(0, 0);

        // Simultaneous requests: data first, instruction right after the data response.
        cycle(1, 0, 32'h200, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 0, 0);
        chk1 ("t2 first is data", mem_instr, 1'b0);
        chk32("t2 data addr", mem_addr, 32'h2000);
        chk32("t2 data wdata", mem_wdata, 32'hDEADBEEF);
        chk32("t2 data wstrb", {28'h0, mem_wstrb}, 32'hF);
        idle(0, 0);
        idle(1, 32'h55);
        chk1 ("t2 d_ready", cap_d_ready, 1'b1);
        chk32("t2 d_rdata", cap_d_rdata, 32'h55);
        chk1 ("t2 i_ready quiet", cap_i_ready, 1'b0);
        chk1 ("t2 instr issues next", mem_valid, 1'b1);
        chk32("t2 instr addr", mem_addr, 32'h200);
        chk32("t2 instr wdata zero", mem_wdata, 32'h0);
        idle(0, 0);
        idle(1, 32'h66);
        chk1 ("t2 i_ready", cap_i_ready, 1'b1);
        chk32("t2 i_rdata", cap_i_rdata, 32'h66);
        idle(0, 0);

        // Latest pending instruction overwrites the older one.
        addr_log.delete();
        cycle(0, 0, 0, 1, 32'h3000, 32'h0, 4'h0, 0, 0);
        cycle(1, 0, 32'h100, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 32'h104, 0, 0, 0, 0, 0, 0);
        idle(1, 32'h77);
        chk32("t3 issued addr", mem_addr, 32'h104);
        chk1 ("t3 fence forwarded", mem_fence, 1'b1);
        idle(0, 0);
        idle(1, 32'h88);
        idle(0, 0);
        hits = 0;
        foreach (addr_log[k]) if (addr_log[k] == 32'h100) hits++;
        chk32("t3 stale addr never issued", hits, 0);

        // Reset while a data access is outstanding.
        cycle(0, 0, 0, 1, 32'h4000, 32'h1, 4'h3, 0, 0);
        idle(0, 0);
        rst = 0;
        idle(0, 0);
        rst = 1;
        idle(1, 32'h99);
        chk1 ("t5 d_ready after reset", cap_d_ready, 1'b0);
        chk1 ("t5 no issue", mem_valid, 1'b0);
        cycle(1, 0, 32'h500, 0, 0, 0, 0, 0, 0);
        chk1 ("t5 issue after reset", mem_valid, 1'b1);
        chk32("t5 addr after reset", mem_addr, 32'h500);
        idle(0, 0);
        idle(1, 32'h1);
        idle(0, 0);

        // Both ports saturated.
        grants.delete();
        for (int c = 0; c < 40; c++) begin
            cycle(1, 0, $urandom, 1, $urandom, $urandom, 4'($urandom),
                  (m_owner != 0) && !m_valid, $urandom);
        end
        n = grants.size();
        chk1("t4 grants seen", n >= 10, 1'b1);
        for (int k = 1; k < n; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            chk1("t4 alternation", grants[k] != grants[k-1], 1'b1);
`else
            chk1("t4 fixed priority", grants[k], DATA_PRIO);
`endif
        end
        for (int c = 0; c < 8; c++) idle((m_owner != 0) && !m_valid, $urandom);

        // Random traffic, occasional resets and stray responses.
        for (int c = 0; c < 4000; c++) begin
            bit mr;
            rst = ($urandom_range(0, 199) != 0);
            if (m_valid) mr = 0;
            else if (m_owner != 0) mr = ($urandom_range(0, 9) < 4);
            else mr = ($urandom_range(0, 9) == 0);
            cycle($urandom_range(0, 9) < 3, 1'($urandom), $urandom,
                  $urandom_range(0, 9) < 3, $urandom, $urandom, 4'($urandom),
                  mr, $urandom);
        end
        rst = 1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-outstanding memory port between the instruction-fetch requester (fetch buffer side) and the data requester (load/store unit).
- Sits between the fetch buffer / LSU and the memory/bus bridge.
- Registers, arbitrates, issues and routes one transaction at a time; the response is returned combinationally to the owning requester.

Parameters:
- DATA_PRIO, 1, fixed-priority tie-break when both ports are pending: 1 = data wins, 0 = instruction wins.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- i_valid  in  1  instruction request strobe
- i_fence  in  1  fence qualifier forwarded with the instruction request
- i_addr  in  32  instruction address
- i_ready  out  1  instruction response valid
- i_rdata  out  32  instruction response data
- d_valid  in  1  data request strobe
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_wstrb  in  4  byte strobes; 0 = load
- d_ready  out  1  data response valid
- d_rdata  out  32  load data
- mem_valid  out  1  memory request, one-cycle pulse
- mem_fence  out  1  fence qualifier
- mem_instr  out  1  1 = instruction access
- mem_addr  out  32  address
- mem_wdata  out  32  write data
- mem_wstrb  out  4  write strobes
- mem_ready  in  1  memory response
- mem_rdata  in  32  memory read data

Behaviour:
- State: IDLE, BUSY_I, BUSY_D. Each port has a one-entry pending slot (valid bit plus captured fields).
- Reset (rst=0 at clk edge):
  - state IDLE, both pending slots cleared.
  - mem_valid, mem_fence, mem_instr = 0; mem_addr, mem_wdata, mem_wstrb = 0.
  - i_ready and d_ready = 0.
  - Reset mid-transaction abandons it. A mem_ready arriving while IDLE is ignored: no i_ready/d_ready.
- Capture: x_valid=1 writes the port's pending slot. A newer request overwrites an unissued pending entry (latest wins). A request arriving while the same port is in flight is held pending.
- Issue:
  - At a clock edge with state IDLE, or BUSY_x with mem_ready=1, the arbiter selects among pending slots plus same-cycle x_valid requests.
  - The winner's fields are registered onto the mem_* outputs, mem_valid=1 for exactly one cycle, state becomes BUSY_I or BUSY_D, and the winner's slot is cleared.
  - Issue latency is 1 cycle: request in cycle N gives mem_valid in cycle N+1.
  - Back-to-back: mem_ready in cycle M gives the next mem_valid in cycle M+1.
- mem_addr, mem_wdata, mem_wstrb, mem_instr and mem_fence hold their values until the next issue.
- Instruction issue forces mem_wdata=0 and mem_wstrb=0. Data issue forces mem_fence=0.
- Response: while in BUSY_I, i_ready=mem_ready and i_rdata=mem_rdata (combinational). BUSY_D behaves likewise for d_ready/d_rdata. The non-owning ready is always 0 and non-owning rdata is 0.
- With no pending request, mem_ready returns the state to IDLE.
- mem_ready is never accepted in the same cycle as mem_valid; the minimum memory latency is 1 cycle.
- Tie-break: DATA_PRIO, unless round-robin is enabled (see Optional Feature).

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
  - Defined: a 1-bit last_grant register (reset: instruction) is added. On a tie, the port not granted last wins. last_grant updates on every issue, and DATA_PRIO is ignored.
  - Undefined: fixed priority per DATA_PRIO; no last_grant register exists.

Test Plan:
1. Reset, then i_valid=1 with i_addr=0x00000100 in cycle 2 -> mem_valid=1, mem_instr=1, mem_addr=0x100 in cycle 3. mem_ready with rdata=0x00000013 in cycle 5 -> i_ready=1, i_rdata=0x13 in cycle 5, d_ready=0.
2. DATA_PRIO=1, i_valid and d_valid (d_addr=0x2000, d_wstrb=0xF, d_wdata=0xDEADBEEF) in the same cycle -> the data access issues first. The instruction access issues in the cycle after the data mem_ready, and each response routes to its own port.
3. Instruction request 0x100 still pending behind a data access, then a new i_valid with 0x104 -> only 0x104 is issued; 0x100 never appears on mem_addr.
4. ARB_ROUND_ROBIN_EN defined, both ports requesting every cycle -> grants alternate I,D,I,D; neither port is granted twice consecutively while the other is pending.
5. rst=0 asserted while BUSY_D, then mem_ready arrives after reset release -> d_ready stays 0, state IDLE. A subsequent i_valid issues normally one cycle later.
